// File: rtl/axi_write_sequencer.sv
// axi_write_sequencer: runs one AXI write at a time.
// It drives level-sensitive go signals to the AW, W and B channel engines and
// collects their done/error results. It checks BID against the command ID,
// abandons the attempt on timeout, and returns one status word per command.
// Optional feature: define WR_RETRY_EN to reissue the write after a BRESP
// error, up to MAX_RETRY times.
module axi_write_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  output logic        aw_go,
  output logic        w_go,
  output logic        b_go,
  output logic [31:0] aw_addr,
  output logic [7:0]  aw_len,
  output logic [3:0]  aw_id,
  input  logic        aw_done,
  input  logic        w_done,
  input  logic        b_done,
  input  logic        b_error,
  input  logic [3:0]  b_id,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_status,
  output logic [1:0]  rsp_retries,
  output logic [2:0]  state_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LAUNCH  = 3'b001,
    S_RUN     = 3'b010,
    S_RELEASE = 3'b011,
    S_REPORT  = 3'b100
  } state_t;

  // The timer is 16 bits wide and the retry count is 2 bits wide.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 2..65536");
  end
  if (MAX_RETRY > 3) begin : g_bad_retry
    $error("MAX_RETRY must fit the 2-bit retry count");
  end

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic        aw_seen, w_seen, b_seen, err_bresp, err_id, tmo;
  logic [1:0]  status_now;
  logic        all_seen, tmo_hit, dones_low, retry_ok;

  // A done that arrives in the same cycle as the check counts as seen.
  assign all_seen  = (aw_seen | aw_done) & (w_seen | w_done) & (b_seen | b_done);
  assign tmo_hit   = (timer == TMO_LAST);
  assign dones_low = ~(aw_done | w_done | b_done);

  // Status priority: timeout, then ID mismatch, then BRESP error, then OKAY.
  always_comb begin
    status_now = 2'b00;
    if (tmo)            status_now = 2'b11;
    else if (err_id)    status_now = 2'b10;
    else if (err_bresp) status_now = 2'b01;
  end

`ifdef WR_RETRY_EN
  logic [1:0] retries;
  // Only a BRESP error is retried. Timeouts and ID mismatches are never retried.
  assign retry_ok    = (status_now == 2'b01) && (32'(retries) < MAX_RETRY);
  assign rsp_retries = retries;
`else
  assign retry_ok    = 1'b0;
  assign rsp_retries = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_nxt = S_LAUNCH;
      S_LAUNCH:  state_nxt = S_RUN;
      S_RUN:     if (all_seen || tmo_hit) state_nxt = S_RELEASE;
      S_RELEASE: if (dones_low) state_nxt = retry_ok ? S_LAUNCH : S_REPORT;
      S_REPORT:  if (rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode. Because go is decoded from the state, an async reset drops it at once.
  always_comb begin
    cmd_ready = (state == S_IDLE);
    aw_go     = (state == S_RUN);
    w_go      = (state == S_RUN);
    b_go      = (state == S_RUN);
    rsp_valid = (state == S_REPORT);
    state_out = state;
  end

  // Command latch, sticky completion flags, timer and result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_addr    <= '0;
      aw_len     <= '0;
      aw_id      <= '0;
      timer      <= '0;
      aw_seen    <= 1'b0;
      w_seen     <= 1'b0;
      b_seen     <= 1'b0;
      err_bresp  <= 1'b0;
      err_id     <= 1'b0;
      tmo        <= 1'b0;
      rsp_status <= '0;
`ifdef WR_RETRY_EN
      retries    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            aw_addr <= cmd_addr;
            aw_len  <= cmd_len;
            aw_id   <= cmd_id;
`ifdef WR_RETRY_EN
            retries <= '0;
`endif
          end
        end
        S_LAUNCH: begin
          aw_seen   <= 1'b0;
          w_seen    <= 1'b0;
          b_seen    <= 1'b0;
          err_bresp <= 1'b0;
          err_id    <= 1'b0;
          tmo       <= 1'b0;
          timer     <= '0;
        end
        S_RUN: begin
          if (aw_done) aw_seen <= 1'b1;
          if (w_done)  w_seen  <= 1'b1;
          if (b_done && !b_seen) begin
            b_seen    <= 1'b1;
            err_bresp <= b_error;
            err_id    <= (b_id != aw_id);
          end
          if (timer != '1) timer <= timer + 16'd1;
          if (tmo_hit && !all_seen) tmo <= 1'b1;
        end
        S_RELEASE: begin
          if (dones_low) begin
`ifdef WR_RETRY_EN
            if (retry_ok) retries <= retries + 2'd1;
            else          rsp_status <= status_now;
`else
            rsp_status <= status_now;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
